// File: rtl/aclk_pkg.sv
// Shared types, defaults and BCD helpers for the alarm-clock core.
package aclk_pkg;

    localparam int TICKS_PER_SEC_DEF = 10;
    localparam int RING_SECS_DEF     = 60;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } alarm_state_e;

    // True when HH:MM is a legal 24-hour BCD time (00:00 .. 23:59).
    function automatic logic bcd_valid_hm(
        input logic [1:0] h1,
        input logic [3:0] h0,
        input logic [3:0] m1,
        input logic [3:0] m0
    );
        logic ok;
        ok = (h1 <= 2'd2) && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9);
        if ((h1 == 2'd2) && (h0 > 4'd3)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/aclk_bcd_time_counter.sv
// Real-time keeper: prescaler plus BCD HH:MM:SS registers with load and
// one-second increment.
module aclk_bcd_time_counter
    import aclk_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_time,
    input  logic [1:0] h1_in,
    input  logic [3:0] h0_in,
    input  logic [3:0] m1_in,
    input  logic [3:0] m0_in,
    output bcd_time_t  time_o,
    output logic       sec_tick_o,
    output logic       presc_zero_o
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    bcd_time_t     time_r;
    bcd_time_t     time_nxt_s;
    bcd_time_t     time_inc_s;
    logic          ld_ok_s;
    logic          sec_tick_s;

    assign sec_tick_s   = (presc_r == PRESC_MAX);
    assign ld_ok_s      = ld_time && bcd_valid_hm(h1_in, h0_in, m1_in, m0_in);
    assign time_o       = time_r;
    assign sec_tick_o   = sec_tick_s;
    assign presc_zero_o = (presc_r == {PW{1'b0}});

    // One-second BCD increment with SS/MM carries and 23:59:59 -> 00:00:00 wrap.
    always_comb begin
        time_inc_s = time_r;
        if (time_r.s0 == 4'd9) begin
            time_inc_s.s0 = 4'd0;
            if (time_r.s1 == 4'd5) begin
                time_inc_s.s1 = 4'd0;
                if (time_r.m0 == 4'd9) begin
                    time_inc_s.m0 = 4'd0;
                    if (time_r.m1 == 4'd5) begin
                        time_inc_s.m1 = 4'd0;
                        if ((time_r.h1 == 2'd2) && (time_r.h0 == 4'd3)) begin
                            time_inc_s.h1 = 2'd0;
                            time_inc_s.h0 = 4'd0;
                        end else if (time_r.h0 == 4'd9) begin
                            time_inc_s.h0 = 4'd0;
                            time_inc_s.h1 = time_r.h1 + 2'd1;
                        end else begin
                            time_inc_s.h0 = time_r.h0 + 4'd1;
                        end
                    end else begin
                        time_inc_s.m1 = time_r.m1 + 4'd1;
                    end
                end else begin
                    time_inc_s.m0 = time_r.m0 + 4'd1;
                end
            end else begin
                time_inc_s.s1 = time_r.s1 + 4'd1;
            end
        end else begin
            time_inc_s.s0 = time_r.s0 + 4'd1;
        end
    end

    // Next time/prescaler: a valid load wins over the increment.
    always_comb begin
        time_nxt_s  = time_r;
        presc_nxt_s = presc_r;
        if (ld_ok_s) begin
            time_nxt_s.h1 = h1_in;
            time_nxt_s.h0 = h0_in;
            time_nxt_s.m1 = m1_in;
            time_nxt_s.m0 = m0_in;
            time_nxt_s.s1 = 4'd0;
            time_nxt_s.s0 = 4'd0;
            presc_nxt_s   = {PW{1'b0}};
        end else if (sec_tick_s) begin
            time_nxt_s  = time_inc_s;
            presc_nxt_s = {PW{1'b0}};
        end else begin
            time_nxt_s  = time_r;
            presc_nxt_s = presc_r + PW'(1);
        end
    end

    // Time and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_r  <= '0;
            presc_r <= {PW{1'b0}};
        end else begin
            time_r  <= time_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

endmodule

// File: rtl/aclk_alarm_ctrl.sv
// Alarm-clock core: time keeper, alarm HH:MM registers, match compare and
// the IDLE/RINGING controller with a seconds-based auto-stop.
module aclk_alarm_ctrl
    import aclk_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int RING_SECS     = RING_SECS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       STOP_al,
    input  logic       AL_ON,
    output logic       Alarm,
    output logic [1:0] H_out1,
    output logic [3:0] H_out0,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0
);

    localparam int RW = (RING_SECS > 0) ? $clog2(RING_SECS + 1) : 1;
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECS);

    bcd_time_t    time_s;
    logic         sec_tick_s;
    logic         presc_zero_s;
    logic [1:0]   al_h1_r;
    logic [3:0]   al_h0_r;
    logic [3:0]   al_m1_r;
    logic [3:0]   al_m0_r;
    logic         match_s;
    alarm_state_e state_r;
    alarm_state_e state_nxt_s;
    logic [RW-1:0] ring_r;
    logic [RW-1:0] ring_nxt_s;
    logic         alarm_r;
    logic         alarm_nxt_s;

    aclk_bcd_time_counter #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_time (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_time      (LD_time),
        .h1_in        (H_in1),
        .h0_in        (H_in0),
        .m1_in        (M_in1),
        .m0_in        (M_in0),
        .time_o       (time_s),
        .sec_tick_o   (sec_tick_s),
        .presc_zero_o (presc_zero_s)
    );

    assign H_out1 = time_s.h1;
    assign H_out0 = time_s.h0;
    assign M_out1 = time_s.m1;
    assign M_out0 = time_s.m0;
    assign S_out1 = time_s.s1;
    assign S_out0 = time_s.s0;
    assign Alarm  = alarm_r;

    // Only one cycle per matching minute: seconds at 00 and prescaler at 0.
    assign match_s = (time_s.h1 == al_h1_r) && (time_s.h0 == al_h0_r) &&
                     (time_s.m1 == al_m1_r) && (time_s.m0 == al_m0_r) &&
                     (time_s.s1 == 4'd0) && (time_s.s0 == 4'd0) && presc_zero_s;

    // Alarm HH:MM registers; invalid loads leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_h1_r <= 2'd0;
            al_h0_r <= 4'd0;
            al_m1_r <= 4'd0;
            al_m0_r <= 4'd0;
        end else if (LD_alarm && bcd_valid_hm(H_in1, H_in0, M_in1, M_in0)) begin
            al_h1_r <= H_in1;
            al_h0_r <= H_in0;
            al_m1_r <= M_in1;
            al_m0_r <= M_in0;
        end else begin
            al_h1_r <= al_h1_r;
            al_h0_r <= al_h0_r;
            al_m1_r <= al_m1_r;
            al_m0_r <= al_m0_r;
        end
    end

    // Controller state, ring-seconds counter and registered Alarm output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ring_r  <= {RW{1'b0}};
            alarm_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ring_r  <= ring_nxt_s;
            alarm_r <= alarm_nxt_s;
        end
    end

    // Next-state: arm on match, leave on stop, disable or ring timeout.
    always_comb begin
        state_nxt_s = state_r;
        ring_nxt_s  = ring_r;
        case (state_r)
            IDLE: begin
                if (match_s && AL_ON && !STOP_al) begin
                    state_nxt_s = RINGING;
                    ring_nxt_s  = RING_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                    ring_nxt_s  = ring_r;
                end
            end
            RINGING: begin
                if (STOP_al || !AL_ON || (ring_r == {RW{1'b0}})) begin
                    state_nxt_s = IDLE;
                    ring_nxt_s  = {RW{1'b0}};
                end else if (sec_tick_s) begin
                    state_nxt_s = RINGING;
                    ring_nxt_s  = ring_r - RW'(1);
                end else begin
                    state_nxt_s = RINGING;
                    ring_nxt_s  = ring_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ring_nxt_s  = {RW{1'b0}};
            end
        endcase
    end

    // Output decode: Alarm follows the state being entered.
    always_comb begin
        alarm_nxt_s = 1'b0;
        case (state_nxt_s)
            RINGING: alarm_nxt_s = 1'b1;
            IDLE:    alarm_nxt_s = 1'b0;
            default: alarm_nxt_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_aclk_alarm_ctrl.sv
// Directed bench for aclk_alarm_ctrl with hand-computed expectations.
module tb_aclk_alarm_ctrl;

    logic       clk;
    logic       rst_n;
    logic       LD_time;
    logic       LD_alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       STOP_al;
    logic       AL_ON;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [3:0] M_out1;
    logic [3:0] M_out0;
    logic [3:0] S_out1;
    logic [3:0] S_out0;

    int total_cnt;
    int bad_cnt;
    int hi_cnt;
    logic seen_hi;

    aclk_alarm_ctrl #(
        .TICKS_PER_SEC(10),
        .RING_SECS    (60)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .STOP_al  (STOP_al),
        .AL_ON    (AL_ON),
        .Alarm    (Alarm),
        .H_out1   (H_out1),
        .H_out0   (H_out0),
        .M_out1   (M_out1),
        .M_out0   (M_out0),
        .S_out1   (S_out1),
        .S_out0   (S_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Current time packed as 24-bit hex HHMMSS for easy reading.
    function automatic logic [23:0] cur_time();
        return {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hm(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
    endtask

    task automatic load_time(input logic [1:0] h1, input logic [3:0] h0,
                             input logic [3:0] m1, input logic [3:0] m0);
        set_hm(h1, h0, m1, m0);
        LD_time = 1'b1;
        tick(1);
        LD_time = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n = 1'b0; LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; AL_ON = 1'b0;
        set_hm(2'd0, 4'd0, 4'd0, 4'd0);
        #12;
        chk_val("rst_time", {8'h0, cur_time()}, 32'h000000);
        chk_val("rst_alarm", {31'd0, Alarm}, 32'd0);
        rst_n = 1'b1;

        // 100 idle cycles: 10 seconds, never ringing
        seen_hi = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (Alarm) seen_hi = 1'b1;
        end
        chk_val("idle_time", {8'h0, cur_time()}, 32'h000010);
        chk_val("idle_no_ring", {31'd0, seen_hi}, 32'd0);

        // alarm 07:30, time 07:29 loaded at E0
        set_hm(2'd0, 4'd7, 4'd3, 4'd0);
        LD_alarm = 1'b1;
        tick(1);
        LD_alarm = 1'b0;
        AL_ON = 1'b1;
        load_time(2'd0, 4'd7, 4'd2, 4'd9);
        chk_val("load_time", {8'h0, cur_time()}, 32'h072900);
        tick(10);
        chk_val("first_sec", {8'h0, cur_time()}, 32'h072901);
        tick(589);
        chk_val("pre_match", {8'h0, cur_time()}, 32'h072959);
        tick(1);
        chk_val("match_time", {8'h0, cur_time()}, 32'h073000);
        chk_val("match_no_alarm_yet", {31'd0, Alarm}, 32'd0);
        tick(1);
        chk_val("alarm_rise", {31'd0, Alarm}, 32'd1);

        // stop for one cycle; no re-rise in the rest of the minute
        STOP_al = 1'b1;
        tick(1);
        STOP_al = 1'b0;
        chk_val("stop_fall", {31'd0, Alarm}, 32'd0);
        seen_hi = 1'b0;
        for (int i = 0; i < 590; i++) begin
            tick(1);
            if (Alarm) seen_hi = 1'b1;
        end
        chk_val("no_retrigger", {31'd0, seen_hi}, 32'd0);
        chk_val("min_end_time", {8'h0, cur_time()}, 32'h073059);

        // ring with no stop: auto stop after about 600 cycles
        load_time(2'd0, 4'd7, 4'd3, 4'd0);
        hi_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            tick(1);
            if (Alarm) hi_cnt++;
        end
        chk_val("auto_stop_len_ok", {31'd0, (hi_cnt >= 590) && (hi_cnt <= 610)}, 32'd1);
        chk_val("auto_stop_low", {31'd0, Alarm}, 32'd0);

        // AL_ON dropped mid-ring
        load_time(2'd0, 4'd7, 4'd3, 4'd0);
        tick(1);
        chk_val("ring2_rise", {31'd0, Alarm}, 32'd1);
        tick(50);
        chk_val("ring2_hold", {31'd0, Alarm}, 32'd1);
        AL_ON = 1'b0;
        tick(1);
        chk_val("alon_drop_fall", {31'd0, Alarm}, 32'd0);
        AL_ON = 1'b1;

        // STOP_al during the match cycle suppresses the alarm
        load_time(2'd0, 4'd7, 4'd3, 4'd0);
        STOP_al = 1'b1;
        tick(1);
        STOP_al = 1'b0;
        seen_hi = Alarm;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (Alarm) seen_hi = 1'b1;
        end
        chk_val("stop_at_match", {31'd0, seen_hi}, 32'd0);

        // 23:59:59 -> 00:00:00 wrap, then invalid loads ignored
        load_time(2'd2, 4'd3, 4'd5, 4'd9);
        chk_val("load_2359", {8'h0, cur_time()}, 32'h235900);
        tick(599);
        chk_val("pre_wrap", {8'h0, cur_time()}, 32'h235959);
        tick(1);
        chk_val("day_wrap", {8'h0, cur_time()}, 32'h000000);
        load_time(2'd2, 4'd5, 4'd1, 4'd0);
        chk_val("bad_h25", {8'h0, cur_time()}, 32'h000000);
        load_time(2'd2, 4'd4, 4'd0, 4'd0);
        chk_val("bad_h24", {8'h0, cur_time()}, 32'h000000);
        load_time(2'd1, 4'd2, 4'd6, 4'd0);
        chk_val("bad_m60", {8'h0, cur_time()}, 32'h000000);

        // invalid alarm load keeps 07:30; then reset mid-ring
        set_hm(2'd2, 4'd5, 4'd3, 4'd0);
        LD_alarm = 1'b1;
        tick(1);
        LD_alarm = 1'b0;
        load_time(2'd0, 4'd7, 4'd3, 4'd0);
        tick(1);
        chk_val("alarm_kept_ring", {31'd0, Alarm}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("async_rst_alarm", {31'd0, Alarm}, 32'd0);
        chk_val("async_rst_time", {8'h0, cur_time()}, 32'h000000);
        #2;
        rst_n = 1'b1;
        // alarm is back at 00:00 and time 00:00:00 matches with AL_ON high
        tick(1);
        chk_val("rst_alarm_0000", {31'd0, Alarm}, 32'd1);
        STOP_al = 1'b1;
        tick(1);
        STOP_al = 1'b0;
        chk_val("final_stop", {31'd0, Alarm}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
